// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared widths, opcode and state encodings for mem_req_engine
package mem_req_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 11;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_SUM  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_req_engine.sv
// rtl/mem_req_engine.sv - command-driven FILL/SUM engine over a word-addressed memory port
module mem_req_engine
  import mem_req_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_rqvalid,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic              mem_rdvalid,
  input  logic [DATA_W-1:0] mem_rddata
);

  localparam int unsigned MAX_LEN = 2 ** ADDR_W;

  state_e            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  ret_cnt;
  logic [DATA_W-1:0] acc;

  logic accept, len_zero, len_big, last_issue, last_ret, rd_live;

  assign accept     = cmd_valid && cmd_ready;
  assign len_zero   = (cmd_len == '0);
  assign len_big    = (32'(cmd_len) > MAX_LEN);
  assign last_issue = (issue_cnt == len_q);
  assign last_ret   = ((ret_cnt + LEN_W'(1)) == len_q);
  assign rd_live    = ((state == READ) || (state == DRAIN)) && mem_rdvalid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (len_zero || len_big)           state_nxt = RESP;
          else if (op_e'(cmd_op) == OP_SUM)  state_nxt = READ;
          else                               state_nxt = FILL;
        end
      end
      FILL:    if (last_issue) state_nxt = RESP;
      READ:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (mem_rdvalid && last_ret) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is gated by reset_n so nothing is offered while reset is held.
  always_comb begin
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    cmd_ready  = (state == IDLE) && reset_n;
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      acc         <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      mem_rqvalid <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_wrdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len_q      <= cmd_len;
            issue_cnt  <= LEN_W'(1);
            ret_cnt    <= '0;
            acc        <= '0;
            mem_addr   <= cmd_addr;
            mem_wrdata <= cmd_data;
            resp_data  <= '0;
            resp_err   <= len_big;
            if (!len_zero && !len_big) begin
              mem_rqvalid <= 1'b1;
              mem_wren    <= (op_e'(cmd_op) == OP_FILL);
            end
          end
        end
        FILL, READ: begin
          if (last_issue) begin
            mem_rqvalid <= 1'b0;
            mem_wren    <= 1'b0;
            if (state == FILL) resp_data <= DATA_W'(len_q);
          end else begin
            issue_cnt  <= issue_cnt + LEN_W'(1);
            mem_addr   <= mem_addr + ADDR_W'(1);
            mem_wrdata <= mem_wrdata + DATA_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
          end
        end
        default: ;
      endcase

      // Read returns lag issue by one cycle, so they straddle READ and DRAIN.
      if (rd_live) begin
        acc     <= acc + mem_rddata;
        ret_cnt <= ret_cnt + LEN_W'(1);
        if ((state == DRAIN) && last_ret) resp_data <= acc + mem_rddata;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_engine.sv
// tb/tb_mem_req_engine.sv - directed self-checking bench for mem_req_engine
module tb_mem_req_engine;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [63:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        mem_rqvalid;
  logic        mem_wren;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wrdata;
  logic        mem_rdvalid;
  logic [63:0] mem_rddata;

  logic [63:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  mem_req_engine dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_rqvalid (mem_rqvalid),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .mem_wrdata  (mem_wrdata),
    .mem_rdvalid (mem_rdvalid),
    .mem_rddata  (mem_rddata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle-latency memory
  always @(posedge clock) begin
    if (mem_rqvalid && mem_wren) mem[mem_addr] <= mem_wrdata;
    mem_rdvalid <= mem_rqvalid && !mem_wren;
    mem_rddata  <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge while idle; returns mid-cycle 1 after acceptance.
  task automatic issue(input logic op, input logic [9:0] a, input logic [10:0] n, input logic [63:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = n;
    cmd_data  = d;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("resp_valid_after_hs", 64'(resp_valid), 64'd0);
    chk("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_fill(input logic [9:0] a, input logic [10:0] n, input logic [63:0] d);
    logic [9:0]  ea;
    logic [63:0] ed;
    issue(1'b0, a, n, d);
    for (int k = 0; k < int'(n); k++) begin
      ea = a + 10'(k);
      ed = d + 64'(k);
      chk("fill_rqvalid", 64'(mem_rqvalid), 64'd1);
      chk("fill_wren", 64'(mem_wren), 64'd1);
      chk("fill_addr", 64'(mem_addr), 64'(ea));
      chk("fill_wrdata", mem_wrdata, ed);
      chk("fill_busy_ready", 64'(cmd_ready), 64'd0);
      chk("fill_no_resp", 64'(resp_valid), 64'd0);
      @(negedge clock);
    end
    chk("fill_resp_valid", 64'(resp_valid), 64'd1);
    chk("fill_resp_data", resp_data, 64'(n));
    chk("fill_resp_err", 64'(resp_err), 64'd0);
    chk("fill_resp_rqvalid", 64'(mem_rqvalid), 64'd0);
    finish_resp();
  endtask

  task automatic run_sum(input logic [9:0] a, input logic [10:0] n, input logic [63:0] exp_sum);
    logic [9:0] ea;
    issue(1'b1, a, n, 64'd0);
    for (int k = 0; k < int'(n); k++) begin
      ea = a + 10'(k);
      chk("sum_rqvalid", 64'(mem_rqvalid), 64'd1);
      chk("sum_wren", 64'(mem_wren), 64'd0);
      chk("sum_addr", 64'(mem_addr), 64'(ea));
      chk("sum_no_resp", 64'(resp_valid), 64'd0);
      @(negedge clock);
    end
    chk("drain_rqvalid", 64'(mem_rqvalid), 64'd0);
    chk("drain_no_resp", 64'(resp_valid), 64'd0);
    @(negedge clock);
    chk("sum_resp_valid", 64'(resp_valid), 64'd1);
    chk("sum_resp_data", resp_data, exp_sum);
    chk("sum_resp_err", 64'(resp_err), 64'd0);
    finish_resp();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"}, resp_data, 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_rqvalid"}, 64'(mem_rqvalid), 64'd0);
    chk({tag, "_wren"}, 64'(mem_wren), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wrdata"}, mem_wrdata, 64'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_data   = '0;
    resp_ready = 1'b0;

    repeat (2) @(negedge clock);
    chk_reset_values("por");
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    run_fill(10'h010, 11'd4, 64'h100);
    run_sum(10'h010, 11'd4, 64'h406);

    run_fill(10'h3FE, 11'd3, 64'hAA);
    run_sum(10'h3FE, 11'd3, 64'h201);

    run_fill(10'h020, 11'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_sum(10'h020, 11'd2, 64'hFFFF_FFFF_FFFF_FFFF);

    issue(1'b1, 10'h010, 11'd0, 64'h0);
    chk("len0_resp_valid", 64'(resp_valid), 64'd1);
    chk("len0_resp_data", resp_data, 64'd0);
    chk("len0_resp_err", 64'(resp_err), 64'd0);
    chk("len0_rqvalid", 64'(mem_rqvalid), 64'd0);
    finish_resp();

    issue(1'b0, 10'h000, 11'd1025, 64'h55);
    for (int k = 0; k < 5; k++) begin
      chk("err_resp_valid", 64'(resp_valid), 64'd1);
      chk("err_resp_err", 64'(resp_err), 64'd1);
      chk("err_resp_data", resp_data, 64'd0);
      chk("err_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("err_rqvalid", 64'(mem_rqvalid), 64'd0);
      @(negedge clock);
    end
    finish_resp();

    run_fill(10'h040, 11'd8, 64'd1);
    issue(1'b1, 10'h040, 11'd8, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_reset_values("mid_sum_reset");
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("aborted_no_resp", 64'(resp_valid), 64'd0);
      chk("aborted_no_req", 64'(mem_rqvalid), 64'd0);
      @(negedge clock);
    end
    run_sum(10'h040, 11'd1, 64'd1);
    run_sum(10'h040, 11'd8, 64'h24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_engine.md
MEM_REQ_ENGINE -- requirements
Module: mem_req_engine

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, word address width; DATA_W, default 64, data width; LEN_W, default 11, length field width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports, clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  1  0=FILL, 1=SUM.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  LEN_W  word count.
- cmd_data  in  DATA_W  FILL seed value.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_data  out  DATA_W  result.
- resp_err  out  1  illegal length flag.
- mem_rqvalid  out  1  memory request strobe.
- mem_wren  out  1  write enable, only with mem_rqvalid.
- mem_addr  out  ADDR_W  memory address.
- mem_wrdata  out  DATA_W  write data.
- mem_rdvalid  in  1  read data valid, one cycle after a request.
- mem_rddata  in  DATA_W  read data.

Function
REQ-004 SHALL implement FSM states IDLE, FILL, READ, DRAIN, RESP; cmd_ready SHALL be high only in IDLE.
REQ-005 On handshake in IDLE: len 0 -> RESP with resp_data 0, resp_err 0; len > 2**ADDR_W -> RESP with resp_data 0, resp_err 1, no memory access; else FILL (op 0) or READ (op 1).
REQ-006 All mem_* outputs SHALL be registered; the first request SHALL appear the cycle after command acceptance.
REQ-007 FILL: for i = 0..len-1, one write per cycle, addr = cmd_addr+i mod 2**ADDR_W, data = cmd_data+i mod 2**DATA_W; then RESP with resp_data = len.
REQ-008 READ: one read per consecutive cycle (mem_rqvalid=1, mem_wren=0) at wrapped addresses; after the last issue go to DRAIN.
REQ-009 SHALL accumulate mem_rddata on every mem_rdvalid in READ/DRAIN, sum mod 2**DATA_W; DRAIN SHALL exit to RESP on the cycle the len-th rdvalid arrives.
REQ-010 SHALL ignore mem_rdvalid in IDLE, FILL and RESP.
REQ-011 Latency from acceptance cycle 0: FILL len N -> resp_valid at cycle N+1; SUM len N -> resp_valid at cycle N+2.
REQ-012 RESP: resp_valid, resp_data and resp_err SHALL be held stable until resp_ready; the handshake returns to IDLE next cycle.
REQ-013 Address wrap: 0x3FF+1 -> 0x000, with no error.
REQ-014 mem_rqvalid SHALL be low in IDLE, DRAIN and RESP; mem_wren SHALL never be high without mem_rqvalid.

Reset
REQ-015 Assertion of reset_n low SHALL immediately force IDLE and clear the counters and accumulator, regardless of state (including mid-FILL and mid-READ).
REQ-016 Reset values: cmd_ready 0 while reset_n is low, then 1; resp_valid 0; resp_data 0; resp_err 0; mem_rqvalid 0; mem_wren 0; mem_addr 0; mem_wrdata 0.
REQ-017 Partial writes issued before reset SHALL NOT be undone; no response SHALL be produced for an aborted command.

Structure
REQ-018 Package mem_req_pkg SHALL hold ADDR_W/DATA_W/LEN_W defaults, the op enum (OP_FILL, OP_SUM) and the state enum.
REQ-019 Single module, no sub-module; one issue counter, one return counter, one DATA_W accumulator.

Verification
REQ-020 FILL addr 0x010, len 4, data 0x100 -> writes 0x100..0x103 at 0x010..0x013 in cycles 1-4; resp_data 4 at cycle 5.
REQ-021 SUM over the previous region -> reads at cycles 1-4; resp_data 0x406, resp_err 0 at cycle 6.
REQ-022 FILL addr 0x3FE, len 3 -> writes at addresses 0x3FE, 0x3FF, 0x000.
REQ-023 len 0 -> resp_data 0, resp_err 0; len 1025 -> resp_err 1, mem_rqvalid never asserted.
REQ-024 resp_ready held low for 5 cycles -> response is stable and cmd_ready stays low; after release, IDLE the next cycle.
REQ-025 reset_n pulsed low mid-SUM len 8 -> all outputs at reset values, no response; a following SUM len 1 completes correctly.
